// File: rtl/edge_cmd_tx_if.sv
// Target-state request channel into edge_cmd_tx. It uses a valid/ready handshake.
interface edge_cmd_tx_if;
  logic       tgt_valid;
  logic [1:0] tgt_state;
  logic       tgt_ready;

  modport master (
    output tgt_valid,
    output tgt_state,
    input  tgt_ready
  );

  modport slave (
    input  tgt_valid,
    input  tgt_state,
    output tgt_ready
  );
endinterface

// File: rtl/edge_cmd_tx.sv
// Edge-count transmitter: emits n=(target-shadow) mod 3 rising pulses on DATA_OUT, then a quiet gap.
// Latency is 1 cycle from acceptance to the first rise. tgt_ready is low from acceptance until the gap ends.
module edge_cmd_tx #(
  parameter int PULSE_HIGH = 4,
  parameter int PULSE_LOW  = 4,
  parameter int GAP        = 16
) (
  input  logic         CLK_IN,
  input  logic         rst,
  edge_cmd_tx_if.slave tgt,
  output logic         DATA_OUT,
  output logic         busy,
  output logic [1:0]   shadow_state,
  output logic         err
);

  localparam int MAX_HL  = (PULSE_HIGH > PULSE_LOW) ? PULSE_HIGH : PULSE_LOW;
  localparam int MAX_PH  = (MAX_HL > GAP) ? MAX_HL : GAP;
  localparam int CW      = (MAX_PH > 1) ? $clog2(MAX_PH) : 1;

  localparam logic [CW-1:0] HIGH_LOAD = CW'(PULSE_HIGH - 1);
  localparam logic [CW-1:0] LOW_LOAD  = CW'(PULSE_LOW - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] phase_cnt;
  logic [1:0]    remaining;
  logic          ready_q;

  logic          accept;
  logic          illegal;
  logic [1:0]    n_edges;
  logic [1:0]    shadow_inc;
  logic [1:0]    rem_dec;

  assign tgt.tgt_ready = ready_q;
  assign accept        = tgt.tgt_valid && ready_q;
  assign illegal       = (tgt.tgt_state == 2'd3);
  assign rem_dec       = remaining - 2'd1;

  // Shadow only ever holds 0..2, so a 2-bit difference plus 3 on underflow gives the mod-3 distance.
  always_comb begin
    n_edges    = 2'd0;
    shadow_inc = 2'd0;
    if (tgt.tgt_state >= shadow_state) begin
      n_edges = tgt.tgt_state - shadow_state;
    end else begin
      n_edges = tgt.tgt_state - shadow_state + 2'd3;
    end
    if (shadow_state != 2'd2) begin
      shadow_inc = shadow_state + 2'd1;
    end
  end

  always_ff @(posedge CLK_IN) begin
    if (rst) begin
      state        <= S_IDLE;
      phase_cnt    <= '0;
      remaining    <= 2'd0;
      ready_q      <= 1'b1;
      busy         <= 1'b0;
      DATA_OUT     <= 1'b0;
      shadow_state <= 2'd0;
      err          <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (illegal) begin
              err <= 1'b1;
            end else if (n_edges != 2'd0) begin
              // The shadow advances together with the rise the remote FSM will see.
              state        <= S_HIGH;
              phase_cnt    <= HIGH_LOAD;
              remaining    <= n_edges;
              DATA_OUT     <= 1'b1;
              shadow_state <= shadow_inc;
              ready_q      <= 1'b0;
              busy         <= 1'b1;
            end
          end
        end

        S_HIGH: begin
          if (phase_cnt == '0) begin
            state     <= S_LOW;
            phase_cnt <= LOW_LOAD;
            DATA_OUT  <= 1'b0;
          end else begin
            phase_cnt <= phase_cnt - CW'(1);
          end
        end

        S_LOW: begin
          if (phase_cnt == '0) begin
            remaining <= rem_dec;
            if (rem_dec != 2'd0) begin
              state        <= S_HIGH;
              phase_cnt    <= HIGH_LOAD;
              DATA_OUT     <= 1'b1;
              shadow_state <= shadow_inc;
            end else begin
              state     <= S_GAP;
              phase_cnt <= GAP_LOAD;
            end
          end else begin
            phase_cnt <= phase_cnt - CW'(1);
          end
        end

        S_GAP: begin
          if (phase_cnt == '0) begin
            state   <= S_IDLE;
            ready_q <= 1'b1;
            busy    <= 1'b0;
          end else begin
            phase_cnt <= phase_cnt - CW'(1);
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_edge_cmd_tx.sv
// Bench for edge_cmd_tx. Expected waveforms are derived from the pulse arithmetic: n pulses of period PH+PL, then GAP.
module tb_edge_cmd_tx;
  localparam int PH = 4;
  localparam int PL = 4;
  localparam int GP = 16;
  localparam int PER = PH + PL;

  logic       CLK_IN = 1'b0;
  logic       rst;
  logic       DATA_OUT;
  logic       busy;
  logic [1:0] shadow_state;
  logic       err;

  edge_cmd_tx_if bus ();

  edge_cmd_tx #(.PULSE_HIGH(PH), .PULSE_LOW(PL), .GAP(GP)) dut (
    .CLK_IN       (CLK_IN),
    .rst          (rst),
    .tgt          (bus),
    .DATA_OUT     (DATA_OUT),
    .busy         (busy),
    .shadow_state (shadow_state),
    .err          (err)
  );

  always #5 CLK_IN = ~CLK_IN;

  int checks = 0;
  int fails  = 0;
  int rises  = 0;
  int model_shadow = 0;

  // Issue one request and check every cycle until the block is idle again (or until the abort).
  task automatic send(input int t, input bit keep, input int abort_k);
    int waitc;
    int n;
    int last;
    int s0;
    int started;
    bit prev;
    bit exp_data;
    bit exp_ready;
    int exp_sh;
    bus.tgt_valid = 1'b1;
    bus.tgt_state = 2'(t);
    waitc = 0;
    while (bus.tgt_ready !== 1'b1 && waitc < 500) begin
      @(negedge CLK_IN);
      waitc++;
    end
    checks++;
    if (bus.tgt_ready !== 1'b1) begin
      fails++;
      $display("FAIL accept_timeout: tgt_ready=%b required 1", bus.tgt_ready);
      bus.tgt_valid = 1'b0;
      return;
    end
    s0 = model_shadow;
    n  = (t == 3) ? 0 : (t + 3 - s0) % 3;
    if (n == 0) begin
      for (int k = 1; k <= 3; k++) begin
        @(negedge CLK_IN);
        if (k == 1) begin
          bus.tgt_valid = 1'b0;
          bus.tgt_state = 2'($urandom_range(0, 3));
        end
        checks++;
        if (DATA_OUT !== 1'b0 || bus.tgt_ready !== 1'b1 || busy !== 1'b0 ||
            shadow_state !== 2'(s0) || err !== ((k == 1 && t == 3) ? 1'b1 : 1'b0)) begin
          fails++;
          $display("FAIL noop_req t=%0d k=%0d: data=%b rdy=%b busy=%b sh=%0d err=%b required data=0 rdy=1 busy=0 sh=%0d err=%0d",
                   t, k, DATA_OUT, bus.tgt_ready, busy, shadow_state, err, s0, (k == 1 && t == 3));
        end
      end
      return;
    end
    last = 1 + n * PER + GP;
    prev = 1'b0;
    for (int k = 1; k <= last; k++) begin
      @(negedge CLK_IN);
      if (k == 1 && !keep) begin
        bus.tgt_valid = 1'b0;
        bus.tgt_state = 2'($urandom_range(0, 3));
      end
      exp_data  = ((k - 1) < n * PER) && (((k - 1) % PER) < PH);
      started   = ((k - 1) < n * PER) ? ((k - 1) / PER + 1) : n;
      exp_sh    = (s0 + started) % 3;
      exp_ready = (k == last);
      checks++;
      if (DATA_OUT !== exp_data || shadow_state !== 2'(exp_sh) || bus.tgt_ready !== exp_ready ||
          busy !== !exp_ready || err !== 1'b0) begin
        fails++;
        $display("FAIL train t=%0d n=%0d k=%0d: data=%b sh=%0d rdy=%b busy=%b err=%b required data=%b sh=%0d rdy=%b busy=%b err=0",
                 t, n, k, DATA_OUT, shadow_state, bus.tgt_ready, busy, err, exp_data, exp_sh, exp_ready, !exp_ready);
      end
      if (DATA_OUT === 1'b1 && !prev) rises++;
      prev = DATA_OUT;
      if (k == abort_k) begin
        rst = 1'b1;
        @(negedge CLK_IN);
        rst = 1'b0;
        bus.tgt_valid = 1'b0;
        checks++;
        if (DATA_OUT !== 1'b0 || shadow_state !== 2'd0 || bus.tgt_ready !== 1'b1 || busy !== 1'b0) begin
          fails++;
          $display("FAIL abort k=%0d: data=%b sh=%0d rdy=%b busy=%b required data=0 sh=0 rdy=1 busy=0",
                   k, DATA_OUT, shadow_state, bus.tgt_ready, busy);
        end
        model_shadow = 0;
        return;
      end
    end
    model_shadow = t;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.tgt_valid = 1'b0;
    bus.tgt_state = 2'd0;
    repeat (3) @(negedge CLK_IN);
    rst = 1'b0;
    @(negedge CLK_IN);
    model_shadow = 0;
    checks++;
    if (DATA_OUT !== 1'b0) begin fails++; $display("FAIL reset_data: %b required 0", DATA_OUT); end
    checks++;
    if (bus.tgt_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: %b required 1", bus.tgt_ready); end
    checks++;
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: %b required 0", busy); end
    checks++;
    if (shadow_state !== 2'd0) begin fails++; $display("FAIL reset_shadow: %0d required 0", shadow_state); end
    checks++;
    if (err !== 1'b0) begin fails++; $display("FAIL reset_err: %b required 0", err); end
  endtask

  task automatic test_two_pulse();
    send(2, 1'b0, 0);
  endtask

  task automatic test_wrap();
    send(0, 1'b0, 0);
  endtask

  task automatic test_equal();
    send(1, 1'b0, 0);
    send(1, 1'b0, 0);
  endtask

  task automatic test_illegal();
    send(3, 1'b0, 0);
    checks++;
    if (shadow_state !== 2'(model_shadow)) begin
      fails++;
      $display("FAIL illegal_shadow: %0d required %0d", shadow_state, model_shadow);
    end
  endtask

  task automatic test_back_to_back();
    int exp_rises;
    send(0, 1'b0, 0);
    exp_rises = ((1 + 3 - model_shadow) % 3) + ((0 + 3 - 1) % 3);
    rises = 0;
    send(1, 1'b1, 0);
    send(0, 1'b1, 0);
    bus.tgt_valid = 1'b0;
    checks++;
    if (rises !== exp_rises) begin
      fails++;
      $display("FAIL b2b_rises: %0d required %0d", rises, exp_rises);
    end
  endtask

  task automatic test_reset_mid_train();
    if (model_shadow != 0) send(0, 1'b0, 0);
    send(2, 1'b0, 6);
    rises = 0;
    send(1, 1'b0, 0);
    checks++;
    if (rises !== 1) begin
      fails++;
      $display("FAIL post_abort_rises: %0d required 1", rises);
    end
  endtask

  task automatic test_random();
    int t;
    bit keep;
    int ab;
    for (int i = 0; i < 25; i++) begin
      t    = $urandom_range(0, 3);
      keep = 1'($urandom_range(0, 1));
      ab   = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 20) : 0;
      send(t, keep, ab);
      bus.tgt_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge CLK_IN);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.tgt_valid = 1'b0;
    bus.tgt_state = 2'd0;
    @(negedge CLK_IN);
    test_reset();
    test_two_pulse();
    test_wrap();
    test_equal();
    test_illegal();
    test_back_to_back();
    test_reset_mid_train();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
